// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions for the TX and RX paths.
//   tx_state_e  : transmitter frame states
//   PAR_EVEN/ODD: parity type encodings for the PAR_TYP control
//   calc_parity : parity bit for a data word (up to MAX_DATA_W bits, zero-extended)
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned MAX_DATA_W = 9;

    // Zero-extension of narrower words does not change the parity.
    function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data, input logic typ);
        logic p;
        p = ^data;
        case (typ)
            PAR_EVEN: return p;
            PAR_ODD:  return ~p;
            default:  return p;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with synchronous active-low reset.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_push, i_data : write request and data (ignored while full)
//   i_pop          : read request (ignored while empty)
//   o_data         : word at the head (valid while !o_empty)
//   o_full/o_empty : status
//   o_count        : words stored, one extra bit so full and empty differ
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_push,
    input  logic [DATA_WIDTH-1:0]         i_data,
    input  logic                          i_pop,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_push_ok;
    logic                  w_pop_ok;

    assign o_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    // Full is judged before any same-edge pop, so a push while full is always dropped.
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// ----------------------------------------------------------------------------
// uart_tx_buffered
// Buffered UART transmitter: FIFO-fed, frame = start | data LSB-first |
// optional parity | 1 or 2 stops. Divider and frame options latched per frame.
// Ports:
//   i_clk, i_rst_n        : clock, synchronous active-low reset
//   i_baud_div            : bit period = i_baud_div+1 cycles
//   i_par_en, i_par_typ   : parity enable, 0 even / 1 odd
//   i_stop2               : two stop bits when set
//   i_in_data/i_in_valid  : word push, accepted when o_in_ready
//   o_in_ready            : FIFO not full
//   o_tx_out              : registered serial line, idles high
//   o_busy                : frame on the line
//   o_fifo_count          : words waiting (excludes the frame on the line)
// ----------------------------------------------------------------------------
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_W      = 6
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [DIV_W-1:0]            i_baud_div,
    input  logic                        i_par_en,
    input  logic                        i_par_typ,
    input  logic                        i_stop2,
    input  logic [DATA_WIDTH-1:0]       i_in_data,
    input  logic                        i_in_valid,
    output logic                        o_in_ready,
    output logic                        o_tx_out,
    output logic                        o_busy,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);

    localparam int unsigned BIT_W = $clog2(DATA_WIDTH);

    tx_state_e             r_state,    w_state_d;
    logic [DIV_W-1:0]      r_baud_cnt, w_baud_cnt_d;
    logic [BIT_W-1:0]      r_bit_idx,  w_bit_idx_d;
    logic [DATA_WIDTH-1:0] r_shift,    w_shift_d;
    logic [DIV_W-1:0]      r_div,      w_div_d;
    logic                  r_par_en,   w_par_en_d;
    logic                  r_par_bit,  w_par_bit_d;
    logic                  r_stop2,    w_stop2_d;
    logic                  r_tx,       w_tx_d;

    logic                  w_tick;
    logic                  w_load;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_fifo_data;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_in_valid),
        .i_data  (i_in_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (o_fifo_count)
    );

    assign o_in_ready = !w_fifo_full;
    assign o_tx_out   = r_tx;
    assign o_busy     = (r_state != IDLE);

    always_comb begin
        w_state_d    = r_state;
        w_bit_idx_d  = r_bit_idx;
        w_shift_d    = r_shift;
        w_div_d      = r_div;
        w_par_en_d   = r_par_en;
        w_par_bit_d  = r_par_bit;
        w_stop2_d    = r_stop2;
        w_load       = 1'b0;
        w_pop        = 1'b0;
        w_tick       = (r_baud_cnt == r_div);

        unique case (r_state)
            IDLE: w_load = !w_fifo_empty;
            START: begin
                if (w_tick) w_state_d = DATA;
            end
            DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == BIT_W'(DATA_WIDTH - 1)) begin
                        w_state_d   = r_par_en ? PARITY : STOP;
                        w_bit_idx_d = '0;
                    end else begin
                        w_bit_idx_d = r_bit_idx + 1'b1;
                        w_shift_d   = r_shift >> 1;
                    end
                end
            end
            PARITY: begin
                if (w_tick) w_state_d = STOP;
            end
            STOP: begin
                // Bit index counts stop bits; the last one chains straight into the next frame.
                if (w_tick) begin
                    if (r_bit_idx == BIT_W'(r_stop2)) begin
                        if (!w_fifo_empty) w_load = 1'b1;
                        else               w_state_d = IDLE;
                    end else begin
                        w_bit_idx_d = r_bit_idx + 1'b1;
                    end
                end
            end
            default: w_state_d = IDLE;
        endcase

        w_baud_cnt_d = (w_tick || r_state == IDLE) ? '0 : r_baud_cnt + 1'b1;

        if (w_load) begin
            w_pop        = 1'b1;
            w_state_d    = START;
            w_shift_d    = w_fifo_data;
            w_div_d      = i_baud_div;
            w_par_en_d   = i_par_en;
            w_par_bit_d  = calc_parity(MAX_DATA_W'(w_fifo_data), i_par_typ);
            w_stop2_d    = i_stop2;
            w_bit_idx_d  = '0;
            w_baud_cnt_d = '0;
        end

        // Line value follows the next state so the output register lines up with it.
        unique case (w_state_d)
            IDLE:    w_tx_d = 1'b1;
            START:   w_tx_d = 1'b0;
            DATA:    w_tx_d = w_shift_d[0];
            PARITY:  w_tx_d = w_par_bit_d;
            STOP:    w_tx_d = 1'b1;
            default: w_tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_div      <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop2    <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_d;
            r_baud_cnt <= w_baud_cnt_d;
            r_bit_idx  <= w_bit_idx_d;
            r_shift    <= w_shift_d;
            r_div      <= w_div_d;
            r_par_en   <= w_par_en_d;
            r_par_bit  <= w_par_bit_d;
            r_stop2    <= w_stop2_d;
            r_tx       <= w_tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_buffered
// Self-checking bench: a queue-based reference model predicts the line
// waveform frame by frame; directed frames plus randomized traffic.
// ----------------------------------------------------------------------------
module tb_uart_tx_buffered;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DIV_W = 6;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic [DIV_W-1:0] baud_div = '0;
    logic             par_en   = 1'b0;
    logic             par_typ  = 1'b0;
    logic             stop2    = 1'b0;
    logic [DW-1:0]    in_data  = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             tx_out;
    logic             busy;
    logic [CNT_W-1:0] fifo_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_tx_buffered #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .DIV_W      (DIV_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_baud_div   (baud_div),
        .i_par_en     (par_en),
        .i_par_typ    (par_typ),
        .i_stop2      (stop2),
        .i_in_data    (in_data),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .o_tx_out     (tx_out),
        .o_busy       (busy),
        .o_fifo_count (fifo_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queue of waiting words, and the line waveform of the
    // frame in flight, one entry per clock cycle.
    logic [DW-1:0] m_fifo[$];
    logic          m_wave[$];
    logic          exp_tx    = 1'b1;
    logic          exp_busy  = 1'b0;
    int            exp_count = 0;
    bit            chk_en    = 1'b0;
    int            busy_cnt  = 0;
    bit            saw_full  = 1'b0;

    task automatic add_symbol(input logic v);
        for (int i = 0; i <= int'(baud_div); i++) m_wave.push_back(v);
    endtask

    task automatic build_frame(input logic [DW-1:0] w);
        logic par;
        par = 1'($countones(w) % 2) ^ par_typ;
        add_symbol(1'b0);
        for (int i = 0; i < DW; i++) add_symbol(w[i]);
        if (par_en) add_symbol(par);
        add_symbol(1'b1);
        if (stop2) add_symbol(1'b1);
    endtask

    initial begin : ref_model
        bit push_ok;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_fifo.delete();
                m_wave.delete();
            end else begin
                push_ok = in_valid && (m_fifo.size() < DEPTH);
                if (m_wave.size() > 0) void'(m_wave.pop_front());
                if (m_wave.size() == 0 && m_fifo.size() > 0) build_frame(m_fifo.pop_front());
                if (push_ok) m_fifo.push_back(in_data);
            end
            exp_busy  = (m_wave.size() > 0);
            exp_tx    = exp_busy ? m_wave[0] : 1'b1;
            exp_count = m_fifo.size();
        end
    end

    initial begin : cycle_checker
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check_eq("tx_out", tx_out, exp_tx);
                check_eq("busy", busy, exp_busy);
                check_eq("fifo_count", fifo_count, exp_count);
                check_eq("in_ready", in_ready, exp_count != DEPTH);
                if (busy) busy_cnt++;
                if (fifo_count == DEPTH && !in_ready) saw_full = 1'b1;
            end
        end
    end

    task automatic push_word(input logic [DW-1:0] w);
        int budget;
        budget   = 5000;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_eq("push_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_busy();
        int budget;
        budget = 5000;
        while (!busy && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_eq("wait_busy", busy, 1);
    endtask

    task automatic wait_idle();
        int budget;
        budget = 20000;
        while ((busy || fifo_count != 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_eq("wait_idle", busy, 0);
    endtask

    // Captures the line while busy; the latest 32 bits land LSB = last cycle.
    task automatic wait_frame(output logic [31:0] bits, output int cycles);
        int budget;
        budget = 5000;
        bits   = '0;
        cycles = 0;
        while (!busy && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        while (busy && budget > 0) begin
            bits = {bits[30:0], tx_out};
            cycles++;
            @(negedge clk);
            budget--;
        end
        check_eq("frame_done", busy, 0);
    endtask

    initial begin : stimulus
        logic [31:0] bits;
        int          cyc;

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check_eq("rst_count", fifo_count, 0);
        check_eq("rst_ready", in_ready, 1);
        check_eq("rst_tx", tx_out, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: even parity, one cycle per bit
        baud_div = '0; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0;
        push_word(8'hAA);
        wait_frame(bits, cyc);
        check_eq("t1_bits", bits[10:0], 11'b00101010101);
        check_eq("t1_len", cyc, 11);

        // 2: odd parity, then no parity with two stops
        par_typ = 1'b1;
        push_word(8'h07);
        wait_frame(bits, cyc);
        check_eq("t2a_bits", bits[10:0], 11'b01110000001);
        check_eq("t2a_len", cyc, 11);
        par_en = 1'b0; stop2 = 1'b1;
        push_word(8'h07);
        wait_frame(bits, cyc);
        check_eq("t2b_bits", bits[10:0], 11'b01110000011);
        check_eq("t2b_len", cyc, 11);

        // 3: 32 cycles per bit
        baud_div = 6'd31; par_en = 1'b0; stop2 = 1'b0;
        push_word(8'h45);
        wait_frame(bits, cyc);
        check_eq("t3_len", cyc, 320);

        // 4: six words with valid held, FIFO fills, frames chain back-to-back
        baud_div = '0; par_en = 1'b1; par_typ = 1'b0;
        busy_cnt = 0; saw_full = 1'b0;
        in_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            int budget;
            budget  = 5000;
            in_data = DW'(i);
            while (!in_ready && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_idle();
        check_eq("t4_busy_total", busy_cnt, 66);
        check_eq("t4_full_seen", saw_full, 1);

        // 5: reset during data bit 3 with two words queued
        baud_div = 6'd3; par_en = 1'b0; stop2 = 1'b0;
        push_word(8'h11);
        wait_busy();
        push_word(8'h22);
        push_word(8'h33);
        check_eq("t5_queued", fifo_count, 2);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("t5_tx", tx_out, 1);
        check_eq("t5_busy", busy, 0);
        check_eq("t5_count", fifo_count, 0);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        check_eq("t5_quiet", busy, 0);

        // 6: config change mid-frame affects only the next frame
        baud_div = '0; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0;
        busy_cnt = 0;
        push_word(8'h5A);
        wait_busy();
        repeat (3) @(negedge clk);
        par_en = 1'b0; baud_div = 6'd3;
        push_word(8'hC3);
        wait_idle();
        check_eq("t6_busy_total", busy_cnt, 51);

        // Randomized traffic, config changes and occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) == 0);
            in_data  = DW'($urandom);
            if ($urandom_range(0, 59) == 0) begin
                baud_div = DIV_W'($urandom_range(0, 3));
                par_en   = 1'($urandom);
                par_typ  = 1'($urandom);
                stop2    = 1'($urandom);
            end
            rst_n = ($urandom_range(0, 499) != 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
